// File: rtl/cmos_capture_win.sv
// Camera pixel capture in the sensor pixel-clock domain: packs BPP bytes per pixel,
// skips the first frames after configuration, crops a window and flags malformed lines.
module cmos_capture_win #(
    parameter int DW          = 8,
    parameter int BPP         = 2,
    parameter int SKIP_FRAMES = 10,
    parameter int VSYNC_POL   = 1,
    parameter int X_START     = 0,
    parameter int Y_START     = 0,
    parameter int WIN_W       = 480,
    parameter int WIN_H       = 272,
    parameter int LINE_W      = 480
) (
    input  logic              cmos_pclk,
    input  logic              sys_rst,
    input  logic              sys_init_done,
    input  logic              cmos_href,
    input  logic              cmos_vsync,
    input  logic [DW-1:0]     cmos_db,
    input  logic              byte_swap,
    output logic              pix_wr_en,
    output logic [DW*BPP-1:0] pix_data,
    output logic              wr_vsync,
    output logic              frame_active,
    output logic              line_err,
    output logic [15:0]       frame_cnt
);
    localparam int PW        = DW * BPP;
    localparam int PHW       = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int CNT_MAX   = (LINE_W > Y_START + WIN_H) ? LINE_W : Y_START + WIN_H;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int SKW       = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam int SKIP_LAST = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

    localparam logic [PHW-1:0] PH_LAST   = PHW'(BPP - 1);
    localparam logic [CW-1:0]  LINE_W_C  = CW'(LINE_W);
    localparam logic [SKW-1:0] SKIP_LAST_C = SKW'(SKIP_LAST);
    localparam logic           VS_ACT    = 1'(VSYNC_POL);

    typedef enum logic [1:0] {IDLE, SKIP, WAIT, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic            href_s1_q, href_s1_d;
    logic            vsync_s1_q, vsync_s1_d;
    logic [DW-1:0]   db_s1_q, db_s1_d;
    logic            href_prev_q, href_prev_d;
    logic            vs_prev_q, vs_prev_d;
    logic [SKW-1:0]  skip_cnt_q, skip_cnt_d;
    logic [PHW-1:0]  phase_q, phase_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic            swap_q, swap_d;
    logic            pix_wr_en_q, pix_wr_en_d;
    logic [PW-1:0]   pix_data_q, pix_data_d;
    logic            wr_vsync_q, wr_vsync_d;
    logic            line_err_q, line_err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic            vs_act, frame_edge, href_fall, in_win, start_frame;
    logic [PW-1:0]   pix_asm;

    assign vs_act     = (vsync_s1_q == VS_ACT);
    assign frame_edge = vs_act && !vs_prev_q;
    assign href_fall  = href_prev_q && !href_s1_q;
    assign in_win     = (int'(x_q) >= X_START) && (int'(x_q) < X_START + WIN_W) &&
                        (int'(y_q) >= Y_START) && (int'(y_q) < Y_START + WIN_H);

    // Drop the current byte into its slot: first byte lands in the MSB unless swapped.
    always_comb begin
        pix_asm = acc_q;
        for (int b = 0; b < BPP; b++) begin
            if (swap_q ? (int'(phase_q) == b) : (int'(phase_q) == BPP - 1 - b))
                pix_asm[b*DW +: DW] = db_s1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        href_s1_d   = cmos_href;
        vsync_s1_d  = cmos_vsync;
        db_s1_d     = cmos_db;
        href_prev_d = href_s1_q;
        vs_prev_d   = vs_act;
        skip_cnt_d  = skip_cnt_q;
        phase_d     = phase_q;
        acc_d       = acc_q;
        x_d         = x_q;
        y_d         = y_q;
        swap_d      = swap_q;
        pix_wr_en_d = 1'b0;
        pix_data_d  = pix_data_q;
        wr_vsync_d  = 1'b0;
        line_err_d  = line_err_q;
        frame_cnt_d = frame_cnt_q;
        start_frame = 1'b0;

        if (!sys_init_done) begin
            state_d    = IDLE;
            skip_cnt_d = '0;
            phase_d    = '0;
            x_d        = '0;
            y_d        = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    skip_cnt_d = '0;
                    if (!vs_act)
                        state_d = (SKIP_FRAMES == 0) ? WAIT : SKIP;
                end
                SKIP: begin
                    if (frame_edge) begin
                        if (skip_cnt_q == SKIP_LAST_C)
                            state_d = WAIT;
                        else
                            skip_cnt_d = skip_cnt_q + SKW'(1);
                    end
                end
                WAIT: begin
                    if (frame_edge) begin
                        start_frame = 1'b1;
                        state_d     = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (frame_edge) begin
                        start_frame = 1'b1;
                    end else if (href_s1_q) begin
                        acc_d = pix_asm;
                        if (phase_q == PH_LAST) begin
                            phase_d = '0;
                            if (in_win) begin
                                pix_wr_en_d = 1'b1;
                                pix_data_d  = pix_asm;
                            end
                            if (x_q != '1)
                                x_d = x_q + CW'(1);
                        end else begin
                            phase_d = phase_q + PHW'(1);
                        end
                    end else if (href_fall) begin
                        if (y_q != '1)
                            y_d = y_q + CW'(1);
                        x_d     = '0;
                        phase_d = '0;
                        if (phase_q != '0 || x_q != LINE_W_C)
                            line_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // A frame edge discards any partial line and its pending error.
            if (start_frame) begin
                wr_vsync_d  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                swap_d      = byte_swap;
                line_err_d  = 1'b0;
                phase_d     = '0;
                x_d         = '0;
                y_d         = '0;
            end
        end
    end

    always_ff @(posedge cmos_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            href_s1_q   <= 1'b0;
            vsync_s1_q  <= 1'b0;
            db_s1_q     <= '0;
            href_prev_q <= 1'b0;
            vs_prev_q   <= 1'b0;
            skip_cnt_q  <= '0;
            phase_q     <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            swap_q      <= 1'b0;
            pix_wr_en_q <= 1'b0;
            pix_data_q  <= '0;
            wr_vsync_q  <= 1'b0;
            line_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            href_s1_q   <= href_s1_d;
            vsync_s1_q  <= vsync_s1_d;
            db_s1_q     <= db_s1_d;
            href_prev_q <= href_prev_d;
            vs_prev_q   <= vs_prev_d;
            skip_cnt_q  <= skip_cnt_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            y_q         <= y_d;
            swap_q      <= swap_d;
            pix_wr_en_q <= pix_wr_en_d;
            pix_data_q  <= pix_data_d;
            wr_vsync_q  <= wr_vsync_d;
            line_err_q  <= line_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pix_wr_en    = pix_wr_en_q;
    assign pix_data     = pix_data_q;
    assign wr_vsync     = wr_vsync_q;
    assign frame_active = (state_q == ACTIVE);
    assign line_err     = line_err_q;
    assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_cmos_capture_win.sv
// Bench for cmos_capture_win: a full-window instance with frame skipping and a small
// cropping instance, each checked against a queue of expected pixels.
module tb_cmos_capture_win;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, init_m, init_c, href, vsync, bswap;
    logic [7:0] db;
    logic        wr_en_m, vs_m, act_m, err_m, wr_en_c, vs_c, act_c, err_c;
    logic [15:0] data_m, fc_m, data_c, fc_c;

    int n_chk = 0, n_fail = 0;
    int n_str_m = 0, n_vs_m = 0, n_str_c = 0, n_vs_c = 0;
    int exp_frames = 0;
    logic [15:0] sb_m[$];
    logic [15:0] sb_c[$];
    logic [15:0] exp_m, exp_c;

    cmos_capture_win #(.DW(8), .BPP(2), .SKIP_FRAMES(2), .VSYNC_POL(1), .X_START(0),
        .Y_START(0), .WIN_W(480), .WIN_H(272), .LINE_W(480)) u_main (
        .cmos_pclk(clk), .sys_rst(rst), .sys_init_done(init_m), .cmos_href(href),
        .cmos_vsync(vsync), .cmos_db(db), .byte_swap(bswap), .pix_wr_en(wr_en_m),
        .pix_data(data_m), .wr_vsync(vs_m), .frame_active(act_m), .line_err(err_m),
        .frame_cnt(fc_m));

    cmos_capture_win #(.DW(8), .BPP(2), .SKIP_FRAMES(0), .VSYNC_POL(1), .X_START(2),
        .Y_START(1), .WIN_W(3), .WIN_H(2), .LINE_W(8)) u_crop (
        .cmos_pclk(clk), .sys_rst(rst), .sys_init_done(init_c), .cmos_href(href),
        .cmos_vsync(vsync), .cmos_db(db), .byte_swap(bswap), .pix_wr_en(wr_en_c),
        .pix_data(data_c), .wr_vsync(vs_c), .frame_active(act_c), .line_err(err_c),
        .frame_cnt(fc_c));

    // Scoreboard side: every strobe pops one expected pixel.
    always @(negedge clk) begin
        if (vs_m) n_vs_m++;
        if (vs_c) n_vs_c++;
        if (wr_en_m) begin
            n_str_m++;
            n_chk++;
            if (sb_m.size() == 0) begin
                n_fail++;
                $display("FAIL main_unexpected_strobe: got pix_data=%h, no pixel expected", data_m);
            end else begin
                exp_m = sb_m.pop_front();
                if (data_m !== exp_m) begin
                    n_fail++;
                    $display("FAIL main_pix_data: got %h expected %h", data_m, exp_m);
                end
            end
        end
        if (wr_en_c) begin
            n_str_c++;
            n_chk++;
            if (sb_c.size() == 0) begin
                n_fail++;
                $display("FAIL crop_unexpected_strobe: got pix_data=%h, no pixel expected", data_c);
            end else begin
                exp_c = sb_c.pop_front();
                if (data_c !== exp_c) begin
                    n_fail++;
                    $display("FAIL crop_pix_data: got %h expected %h", data_c, exp_c);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pix_word(input int l, input int p);
        return {7'(l), 9'(p)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        href = 1'b0;
        db   = 8'h00;
        repeat (n) cycle();
    endtask

    task automatic send_vs();
        vsync = 1'b1;
        repeat (3) cycle();
        vsync = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic send_line(input int l, input int npix, input int extra, input bit pm, input bit pc);
        logic [15:0] w;
        for (int p = 0; p < npix; p++) begin
            w = pix_word(l, p);
            if (pm) sb_m.push_back(bswap ? {w[7:0], w[15:8]} : w);
            if (pc && l >= 1 && l < 3 && p >= 2 && p < 5) sb_c.push_back(w);
            href = 1'b1;
            db   = w[15:8];
            cycle();
            db   = w[7:0];
            cycle();
        end
        for (int e = 0; e < extra; e++) begin
            href = 1'b1;
            db   = 8'hEE;
            cycle();
        end
        idle(4);
    endtask

    task automatic test_reset();
        logic [15:0] w;
        int s0, v0;
        rst = 1'b1; init_m = 1'b0; init_c = 1'b0;
        href = 1'b0; vsync = 1'b0; db = 8'h00; bswap = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        idle(3);
        init_m = 1'b1;
        idle(5);
        send_vs(); send_line(0, 4, 0, 0, 0);
        send_vs(); send_line(0, 4, 0, 0, 0);
        send_vs(); exp_frames = 1;
        n_chk++; if (act_m !== 1'b1) begin n_fail++; $display("FAIL reset_pre_active: got %b expected 1", act_m); end
        n_chk++; if (fc_m !== 16'd1) begin n_fail++; $display("FAIL reset_pre_frame_cnt: got %0d expected 1", fc_m); end
        for (int p = 0; p < 20; p++) begin
            w = pix_word(0, p);
            if (p < 19) sb_m.push_back(w);
            href = 1'b1; db = w[15:8]; cycle();
            db = w[7:0]; cycle();
        end
        w = pix_word(0, 20);
        db = w[15:8];
        cycle();
        w = pix_word(0, 19);
        n_chk++; if (wr_en_m !== 1'b1 || data_m !== w) begin n_fail++;
            $display("FAIL reset_pre_strobe: got en=%b data=%h expected en=1 data=%h", wr_en_m, data_m, w); end
        #1 rst = 1'b1;
        #1;
        n_chk++; if (wr_en_m !== 1'b0) begin n_fail++; $display("FAIL reset_pix_wr_en: got %b expected 0", wr_en_m); end
        n_chk++; if (data_m !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data: got %h expected 0000", data_m); end
        n_chk++; if (vs_m !== 1'b0) begin n_fail++; $display("FAIL reset_wr_vsync: got %b expected 0", vs_m); end
        n_chk++; if (act_m !== 1'b0) begin n_fail++; $display("FAIL reset_frame_active: got %b expected 0", act_m); end
        n_chk++; if (err_m !== 1'b0) begin n_fail++; $display("FAIL reset_line_err: got %b expected 0", err_m); end
        n_chk++; if (fc_m !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc_m); end
        href = 1'b0; db = 8'h00; init_m = 1'b0; exp_frames = 0;
        repeat (2) cycle();
        rst = 1'b0;
        idle(3);
        s0 = n_str_m; v0 = n_vs_m;
        repeat (5) begin send_vs(); send_line(0, 8, 0, 0, 0); end
        n_chk++; if (n_str_m - s0 != 0) begin n_fail++; $display("FAIL idle_strobes: got %0d expected 0", n_str_m - s0); end
        n_chk++; if (n_vs_m - v0 != 0) begin n_fail++; $display("FAIL idle_wr_vsync: got %0d expected 0", n_vs_m - v0); end
        n_chk++; if (sb_m.size() != 0) begin n_fail++; $display("FAIL reset_sb_left: got %0d pending expected 0", sb_m.size()); end
        $display("test_reset done");
    endtask

    task automatic test_skip();
        int s0, v0;
        init_m = 1'b1; bswap = 1'b0;
        idle(5);
        s0 = n_str_m; v0 = n_vs_m;
        for (int f = 0; f < 4; f++) begin
            send_vs();
            if (f >= 2) exp_frames++;
            for (int l = 0; l < 4; l++) send_line(l, 480, 0, f >= 2, 0);
        end
        n_chk++; if (n_vs_m - v0 != 2) begin n_fail++; $display("FAIL skip_wr_vsync: got %0d expected 2", n_vs_m - v0); end
        n_chk++; if (n_str_m - s0 != 3840) begin n_fail++; $display("FAIL skip_strobes: got %0d expected 3840", n_str_m - s0); end
        n_chk++; if (fc_m !== 16'(exp_frames)) begin n_fail++; $display("FAIL skip_frame_cnt: got %0d expected %0d", fc_m, exp_frames); end
        n_chk++; if (err_m !== 1'b0) begin n_fail++; $display("FAIL skip_line_err: got %b expected 0", err_m); end
        n_chk++; if (sb_m.size() != 0) begin n_fail++; $display("FAIL skip_sb_left: got %0d pending expected 0", sb_m.size()); end
        $display("test_skip done");
    endtask

    task automatic test_pack_swap();
        bswap = 1'b0;
        send_vs(); exp_frames++;
        href = 1'b1; db = 8'hAB; cycle();
        db = 8'hCD; sb_m.push_back(16'hABCD); cycle();
        n_chk++; if (wr_en_m !== 1'b0) begin n_fail++; $display("FAIL pack_latency_early: got %b expected 0", wr_en_m); end
        href = 1'b0; db = 8'h00; cycle();
        n_chk++; if (wr_en_m !== 1'b1 || data_m !== 16'hABCD) begin n_fail++;
            $display("FAIL pack_noswap: got en=%b data=%h expected en=1 data=abcd", wr_en_m, data_m); end
        idle(4);
        n_chk++; if (err_m !== 1'b1) begin n_fail++; $display("FAIL pack_short_err: got %b expected 1", err_m); end
        bswap = 1'b1;
        send_vs(); exp_frames++;
        n_chk++; if (err_m !== 1'b0) begin n_fail++; $display("FAIL pack_err_clear: got %b expected 0", err_m); end
        bswap = 1'b0;
        href = 1'b1; db = 8'hAB; cycle();
        db = 8'hCD; sb_m.push_back(16'hCDAB); cycle();
        db = 8'h12; cycle();
        n_chk++; if (wr_en_m !== 1'b1 || data_m !== 16'hCDAB) begin n_fail++;
            $display("FAIL pack_swap: got en=%b data=%h expected en=1 data=cdab", wr_en_m, data_m); end
        db = 8'h34; sb_m.push_back(16'h3412); cycle();
        idle(6);
        n_chk++; if (data_m !== 16'h3412) begin n_fail++; $display("FAIL pack_hold: got %h expected 3412", data_m); end
        n_chk++; if (fc_m !== 16'(exp_frames)) begin n_fail++; $display("FAIL pack_frame_cnt: got %0d expected %0d", fc_m, exp_frames); end
        $display("test_pack_swap done");
    endtask

    task automatic test_line_err();
        int s0;
        bswap = 1'b0;
        send_vs(); exp_frames++;
        n_chk++; if (err_m !== 1'b0) begin n_fail++; $display("FAIL short_err_start: got %b expected 0", err_m); end
        send_line(0, 479, 0, 1, 0);
        n_chk++; if (err_m !== 1'b1) begin n_fail++; $display("FAIL short_err_set: got %b expected 1", err_m); end
        send_vs(); exp_frames++;
        n_chk++; if (err_m !== 1'b0) begin n_fail++; $display("FAIL short_err_clear: got %b expected 0", err_m); end
        s0 = n_str_m;
        send_line(1, 480, 1, 1, 0);
        n_chk++; if (err_m !== 1'b1) begin n_fail++; $display("FAIL partial_err_set: got %b expected 1", err_m); end
        n_chk++; if (n_str_m - s0 != 480) begin n_fail++; $display("FAIL partial_strobes: got %0d expected 480", n_str_m - s0); end
        n_chk++; if (sb_m.size() != 0) begin n_fail++; $display("FAIL partial_sb_left: got %0d pending expected 0", sb_m.size()); end
        $display("test_line_err done");
    endtask

    task automatic test_abort();
        logic [15:0] w;
        int s0, v0;
        send_vs(); exp_frames++;
        s0 = n_str_m;
        for (int p = 0; p < 100; p++) begin
            w = pix_word(2, p);
            sb_m.push_back(w);
            href = 1'b1; db = w[15:8]; cycle();
            db = w[7:0]; cycle();
        end
        w = pix_word(2, 100);
        db = w[15:8]; cycle();
        init_m = 1'b0; db = w[7:0]; cycle();
        n_chk++; if (act_m !== 1'b0) begin n_fail++; $display("FAIL abort_frame_active: got %b expected 0", act_m); end
        for (int p = 101; p < 150; p++) begin
            w = pix_word(2, p);
            db = w[15:8]; cycle();
            db = w[7:0]; cycle();
        end
        idle(4);
        n_chk++; if (n_str_m - s0 != 100) begin n_fail++; $display("FAIL abort_strobes: got %0d expected 100", n_str_m - s0); end
        init_m = 1'b1;
        idle(5);
        s0 = n_str_m; v0 = n_vs_m;
        send_vs(); send_line(0, 4, 0, 0, 0);
        send_vs(); send_line(0, 4, 0, 0, 0);
        n_chk++; if (act_m !== 1'b0) begin n_fail++; $display("FAIL abort_resume_early: got %b expected 0", act_m); end
        send_vs(); exp_frames++;
        send_line(0, 4, 0, 1, 0);
        n_chk++; if (n_vs_m - v0 != 1) begin n_fail++; $display("FAIL abort_resume_vsync: got %0d expected 1", n_vs_m - v0); end
        n_chk++; if (n_str_m - s0 != 4) begin n_fail++; $display("FAIL abort_resume_strobes: got %0d expected 4", n_str_m - s0); end
        n_chk++; if (fc_m !== 16'(exp_frames)) begin n_fail++; $display("FAIL abort_frame_cnt: got %0d expected %0d", fc_m, exp_frames); end
        n_chk++; if (act_m !== 1'b1) begin n_fail++; $display("FAIL abort_resume_active: got %b expected 1", act_m); end
        $display("test_abort done");
    endtask

    task automatic test_crop();
        int s0;
        init_m = 1'b0; bswap = 1'b0;
        init_c = 1'b1;
        idle(5);
        s0 = n_str_c;
        send_vs();
        for (int l = 0; l < 4; l++) send_line(l, 8, 0, 0, 1);
        n_chk++; if (n_str_c - s0 != 6) begin n_fail++; $display("FAIL crop_strobes: got %0d expected 6", n_str_c - s0); end
        n_chk++; if (sb_c.size() != 0) begin n_fail++; $display("FAIL crop_sb_left: got %0d pending expected 0", sb_c.size()); end
        n_chk++; if (err_c !== 1'b0) begin n_fail++; $display("FAIL crop_line_err: got %b expected 0", err_c); end
        n_chk++; if (fc_c !== 16'd1 || n_vs_c != 1) begin n_fail++;
            $display("FAIL crop_frames: got frame_cnt=%0d vsyncs=%0d expected 1 and 1", fc_c, n_vs_c); end
        n_chk++; if (sb_m.size() != 0) begin n_fail++; $display("FAIL main_sb_left: got %0d pending expected 0", sb_m.size()); end
        $display("test_crop done");
    endtask

    initial begin
        test_reset();
        test_skip();
        test_pack_swap();
        test_line_err();
        test_abort();
        test_crop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cmos_capture_win.md
Name: cmos_capture_win

Overview:
- Parametrised camera pixel-capture block running in the sensor pixel-clock domain. Successor to the fixed 8-to-16-bit OV5640 capture stage.
- Packs BPP sensor bytes into one pixel, with optional byte swap.
- Drops the first SKIP_FRAMES frames after configuration completes.
- Crops a programmable window and flags malformed lines.
- Output feeds the frame-buffer write FIFO: pix_wr_en, pix_data, wr_vsync.

Parameters:
- DW, 8: sensor data bus width.
- BPP, 2: bytes per pixel (1..4); pixel width = DW*BPP.
- SKIP_FRAMES, 10: complete frames discarded after sys_init_done rises (0 = none).
- VSYNC_POL, 1: active level of cmos_vsync.
- X_START, 0: first kept pixel column.
- Y_START, 0: first kept line.
- WIN_W, 480: kept pixels per line.
- WIN_H, 272: kept lines per frame.
- LINE_W, 480: expected pixels per href period, used for the error check.

Ports:
- cmos_pclk, in, 1: sole clock; all logic on the rising edge.
- sys_rst, in, 1: asynchronous, active-high reset.
- sys_init_done, in, 1: sensor configuration complete; capture enable.
- cmos_href, in, 1: line-valid.
- cmos_vsync, in, 1: frame sync; polarity set by VSYNC_POL.
- cmos_db, in, DW: sensor byte.
- byte_swap, in, 1: 0 = first byte is the pixel MSB; 1 = first byte is the pixel LSB.
- pix_wr_en, out, 1: pixel valid strobe.
- pix_data, out, DW*BPP: packed pixel.
- wr_vsync, out, 1: one-cycle pulse at the start of each kept frame.
- frame_active, out, 1: high while in ACTIVE.
- line_err, out, 1: sticky line-length/partial-pixel error.
- frame_cnt, out, 16: number of kept frames, wraps at 0xFFFF -> 0.

Behaviour:
- Reset: sys_rst clears all state and outputs asynchronously.
  - Outputs go to 0; pix_data goes to 0; state = IDLE.
- Input stage: cmos_href, cmos_vsync and cmos_db are registered once (stage 1).
  - All detection runs on stage-1 values.
- Frame edge: stage-1 vsync goes from inactive to active (per VSYNC_POL).
- State machine:
  - IDLE: go to SKIP when sys_init_done=1 and vsync is inactive. If SKIP_FRAMES=0, go directly to WAIT.
  - SKIP: count frame edges. After SKIP_FRAMES edges go to WAIT. No outputs.
  - WAIT: on the next frame edge go to ACTIVE and pulse wr_vsync for one cycle on the edge cycle.
  - ACTIVE: capture pixels. Each subsequent frame edge re-pulses wr_vsync, increments frame_cnt, clears x/y and line_err, and stays in ACTIVE.
- sys_init_done low in any state: return to IDLE on the next cycle; pix_wr_en is forced low from that cycle. No partial pixel is emitted.
- Byte packing:
  - A byte-phase counter runs 0..BPP-1 on each stage-1 href-high cycle.
  - At phase BPP-1 a pixel is complete and x increments.
  - byte_swap=0: first byte in the MSB slot. byte_swap=1: first byte in the LSB slot.
  - byte_swap is sampled at each frame edge and held constant for the frame.
- Windowing: pixel is emitted when X_START <= x < X_START+WIN_W and Y_START <= y < Y_START+WIN_H.
  - Emission means pix_wr_en=1 for one cycle with pix_data valid.
  - Latency: 2 cycles from the last pixel byte at cmos_db to pix_wr_en.
  - pix_data holds its value when pix_wr_en=0.
- Line end (stage-1 href falling edge):
  - y increments; x and the phase counter clear.
  - If the phase counter is nonzero, the partial pixel is discarded and line_err is set.
  - If the completed pixel count != LINE_W, line_err is set.
  - line_err stays set until the next frame edge. Checks run in ACTIVE only.
- Wrap: x and y saturate at their maximum value (no wrap). Their width must hold LINE_W and Y_START+WIN_H.
- Simultaneous href falling edge and frame edge: the frame edge wins.
  - Counters clear and line_err clears.
  - The error from the truncated line is not reported.
- Vsync active while href is high: treated as a frame edge; the partial line is dropped without error.
- Lines beyond Y_START+WIN_H are counted but never emitted.
- frame_active: 1 in ACTIVE, otherwise 0.

Test Plan:
- Reset/idle: assert sys_rst mid-line with ACTIVE capture.
  - Required: all outputs 0 in the same cycle, state IDLE.
  - After release with sys_init_done=0: 5 frames produce no pix_wr_en and no wr_vsync.
- Frame skip (SKIP_FRAMES=2): raise sys_init_done, then send 4 frames of 4 lines x 480 pixels, BPP=2.
  - Required: frames 1-2 dropped; wr_vsync pulses twice; 480x4x2 = 3840 pix_wr_en strobes; frame_cnt=2.
- Packing/swap: send bytes 0xAB, 0xCD.
  - byte_swap=0 -> pix_data=0xABCD.
  - Next frame with byte_swap=1 -> pix_data=0xCDAB.
  - pix_wr_en rises exactly 2 cycles after 0xCD is presented.
- Crop: X_START=2, WIN_W=3, Y_START=1, WIN_H=2, LINE_W=8; 4 lines of pixels 0..7.
  - Required: 6 strobes total, carrying pixels 2,3,4 of lines 1 and 2 only.
- Line error, short line: one line of 479 pixels -> line_err=1 after its href fall; the next frame edge clears it.
- Line error, partial pixel: one line of 961 bytes -> line_err=1 and the partial pixel is not emitted.
- Abort: drop sys_init_done at pixel 100 of a line.
  - Required: no strobes from the next cycle on; frame_active=0.
  - After sys_init_done returns, capture resumes only after the skip count plus one frame edge.
